// File: rtl/store_buffer_dmem.sv
// store_buffer_dmem: MEM-stage data memory with a FIFO store buffer draining into a slow word RAM
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   ALUResultM            - byte address; word index taken from bits [log2(MEM_WORDS)+1:2]
//   WriteDataM, MemWriteM - store data and store strobe
//   MemReadM              - load strobe, ignored when MemWriteM is high
//   ReadDataM             - combinational load data (0 when no load)
//   MemStallM             - hold the MEM stage and everything upstream
//   SbEmptyM, SbCountM    - buffer empty with drain idle, number of valid entries
module store_buffer_dmem #(
   parameter int MEM_WORDS = 64,
   parameter int SB_DEPTH  = 4,
   parameter int WR_LAT    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [31:0]               ALUResultM,
   input  logic [31:0]               WriteDataM,
   input  logic                      MemWriteM,
   input  logic                      MemReadM,
   output logic [31:0]               ReadDataM,
   output logic                      MemStallM,
   output logic                      SbEmptyM,
   output logic [$clog2(SB_DEPTH):0] SbCountM
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int PW = $clog2(SB_DEPTH);
   localparam int CW = WR_LAT > 1 ? $clog2(WR_LAT) : 1;
   localparam logic [CW-1:0] LAST = CW'(WR_LAT - 1);
   localparam logic [PW:0] FULL = (PW+1)'(SB_DEPTH);

   typedef enum logic {IDLE, WRITE} stateT;

   stateT               state;
   logic [CW-1:0]       wcnt;
   logic [PW-1:0]       headPtr, tailPtr;
   logic [PW:0]         count;
   logic [SB_DEPTH-1:0] sbValid;
   logic [AW-1:0]       sbIdx [SB_DEPTH];
   logic [31:0]         sbData [SB_DEPTH];
   logic [31:0]         ram [MEM_WORDS];
   logic [AW-1:0]       wordIdx;
   logic                load, hit, pop, enq;
   logic [31:0]         hitData;
   logic                unusedAddr;

   assign wordIdx    = ALUResultM[AW+1:2];
   assign unusedAddr = ^{ALUResultM[31:AW+2], ALUResultM[1:0]};
   assign load       = MemReadM & ~MemWriteM;
   assign pop        = state == WRITE && wcnt == LAST;
   assign MemStallM  = (MemWriteM && count == FULL && !pop) || (load && !hit && state == WRITE);
   assign enq        = MemWriteM & ~MemStallM;
   assign ReadDataM  = !load ? '0 : hit ? hitData : ram[wordIdx];
   assign SbEmptyM   = count == '0 && state == IDLE;
   assign SbCountM   = count;

   // Walk from oldest (head) to youngest so the last match is the youngest store.
   always_comb begin
      hit     = 1'b0;
      hitData = '0;
      for (int k = 0; k < SB_DEPTH; k++) begin
         if (sbValid[headPtr + PW'(k)] && sbIdx[headPtr + PW'(k)] == wordIdx) begin
            hit     = 1'b1;
            hitData = sbData[headPtr + PW'(k)];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         wcnt    <= '0;
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
         sbValid <= '0;
      end else begin
         // Pop clears before enqueue sets, so a full-buffer pop+enqueue reuses the slot.
         if (pop) begin
            sbValid[headPtr] <= 1'b0;
            headPtr          <= headPtr + 1'b1;
         end
         if (enq) begin
            sbValid[tailPtr] <= 1'b1;
            tailPtr          <= tailPtr + 1'b1;
         end
         count <= count + (PW+1)'(enq) - (PW+1)'(pop);
         if (state == IDLE) begin
            wcnt <= '0;
            if (count != '0 && !load) state <= WRITE;
         end else if (!pop) begin
            wcnt <= wcnt + 1'b1;
         end else begin
            // A store enqueued on this edge is not eligible until the next edge.
            wcnt  <= '0;
            state <= (count > (PW+1)'(1) && !load) ? WRITE : IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         sbIdx[tailPtr]  <= wordIdx;
         sbData[tailPtr] <= WriteDataM;
      end
      if (pop) ram[sbIdx[headPtr]] <= sbData[headPtr];
   end
endmodule

// File: tb/tb_store_buffer_dmem.sv
// tb_store_buffer_dmem: randomized and directed checks of store_buffer_dmem against a queue-based model
module tb_store_buffer_dmem;
   logic        clk, reset;
   logic [31:0] aluRes [2];
   logic [31:0] wrData [2];
   logic        memWr [2];
   logic        memRd [2];
   logic [31:0] rdData [2];
   logic        stallO [2];
   logic        emptyO [2];
   logic [2:0]  cnt0;
   logic [1:0]  cnt1;
   int          vecs, miss;
   bit          chkOn;

   // Model: per instance a FIFO of pending stores, a busy flag and cycles left until the head pops.
   int          qn [2];
   logic [5:0]  qI [2][8];
   logic [31:0] qD [2][8];
   bit          busy [2];
   int          left [2];
   logic [31:0] mram [2][64];
   logic [31:0] pre [2][64];

   store_buffer_dmem #(.MEM_WORDS(64), .SB_DEPTH(4), .WR_LAT(2)) dut0 (
      .clk(clk), .reset(reset), .ALUResultM(aluRes[0]), .WriteDataM(wrData[0]),
      .MemWriteM(memWr[0]), .MemReadM(memRd[0]), .ReadDataM(rdData[0]),
      .MemStallM(stallO[0]), .SbEmptyM(emptyO[0]), .SbCountM(cnt0));

   store_buffer_dmem #(.MEM_WORDS(64), .SB_DEPTH(2), .WR_LAT(4)) dut1 (
      .clk(clk), .reset(reset), .ALUResultM(aluRes[1]), .WriteDataM(wrData[1]),
      .MemWriteM(memWr[1]), .MemReadM(memRd[1]), .ReadDataM(rdData[1]),
      .MemStallM(stallO[1]), .SbEmptyM(emptyO[1]), .SbCountM(cnt1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dep(input int k);
      return k == 0 ? 4 : 2;
   endfunction

   function automatic int lat(input int k);
      return k == 0 ? 2 : 4;
   endfunction

   function automatic void comb(input int k, output bit ld, output bit pop, output bit stl,
                                output logic [31:0] erd);
      logic [5:0]  idx;
      bit          hit;
      logic [31:0] hd;
      idx = aluRes[k][7:2];
      ld  = memRd[k] && !memWr[k];
      hit = 1'b0;
      hd  = '0;
      for (int i = 0; i < qn[k]; i++)
         if (qI[k][i] == idx) begin
            hit = 1'b1;
            hd  = qD[k][i];
         end
      pop = busy[k] && left[k] == 1;
      stl = (memWr[k] && qn[k] == dep(k) && !pop) || (ld && !hit && busy[k]);
      erd = !ld ? 32'h0 : hit ? hd : mram[k][idx];
   endfunction

   function automatic void mclear();
      for (int k = 0; k < 2; k++) begin
         qn[k]   = 0;
         busy[k] = 1'b0;
         left[k] = 0;
      end
   endfunction

   function automatic void step(input int k);
      bit          ld, pop, stl;
      logic [31:0] erd;
      comb(k, ld, pop, stl, erd);
      if (pop) begin
         mram[k][qI[k][0]] = qD[k][0];
         for (int i = 0; i < qn[k] - 1; i++) begin
            qI[k][i] = qI[k][i+1];
            qD[k][i] = qD[k][i+1];
         end
         qn[k]--;
      end
      if (busy[k] && !pop) left[k]--;
      else if (pop) begin
         if (qn[k] > 0 && !ld) left[k] = lat(k);
         else busy[k] = 1'b0;
      end else if (qn[k] > 0 && !ld) begin
         busy[k] = 1'b1;
         left[k] = lat(k);
      end
      if (memWr[k] && !stl) begin
         qI[k][qn[k]] = aluRes[k][7:2];
         qD[k][qn[k]] = wrData[k];
         qn[k]++;
      end
   endfunction

   always @(posedge clk) begin
      if (reset) mclear();
      else begin
         step(0);
         step(1);
      end
   end

   task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s dut%0d t=%0t got %h want %h", nm, k, $time, act, exp);
      end
   endtask

   task automatic checkAll();
      bit          ld, pop, stl;
      logic [31:0] erd;
      for (int k = 0; k < 2; k++) begin
         comb(k, ld, pop, stl, erd);
         cmp("stall", k, 32'(stallO[k]), 32'(stl));
         cmp("empty", k, 32'(emptyO[k]), 32'(qn[k] == 0 && !busy[k]));
         cmp("count", k, k == 0 ? 32'(cnt0) : 32'(cnt1), 32'(qn[k]));
         if (!stl) cmp("rdata", k, rdData[k], erd);
      end
   endtask

   always @(negedge clk) if (chkOn) checkAll();

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setIn(input int k, input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
      memWr[k]  = w;
      memRd[k]  = r;
      aluRes[k] = a;
      wrData[k] = d;
   endtask

   // Present one operation, holding it while the model says the stage is stalled.
   task automatic op(input int k, input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
      bit          ld, pop, stl;
      logic [31:0] erd;
      int          n;
      setIn(k, w, r, a, d);
      n = 0;
      do begin
         #2;
         comb(k, ld, pop, stl, erd);
         @(posedge clk);
         #1;
         n++;
      end while (stl && n < 100);
      vecs++;
      if (stl) begin
         miss++;
         $display("FAIL op_timeout dut%0d t=%0t got stalled want released", k, $time);
      end
   endtask

   task automatic drain(input int k);
      int n;
      setIn(k, 0, 0, 0, 0);
      n = 0;
      while ((qn[k] != 0 || busy[k]) && n < 200) begin
         tick();
         n++;
      end
      vecs++;
      if (qn[k] != 0 || busy[k]) begin
         miss++;
         $display("FAIL drain_timeout dut%0d t=%0t got count %0d want 0", k, $time, qn[k]);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog t=%0t got running want finished", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          r;
      vecs  = 0;
      miss  = 0;
      chkOn = 1'b0;
      reset = 1'b1;
      for (int k = 0; k < 2; k++) setIn(k, 0, 0, 0, 0);
      mclear();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 64; i++) begin
            mram[k][i] = 32'h0;
            pre[k][i]  = i == 16 ? 32'h55 : $urandom;
         end
      tick();
      tick();
      reset = 1'b0;
      chkOn = 1'b1;
      // Preload both RAMs through the store path.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 64; i++) op(k, 1, 0, 32'(i * 4), pre[k][i]);
         drain(k);
      end
      // Reset asserted mid-cycle with a store pending.
      setIn(0, 1, 0, 32'h04, 32'h1234);
      tick();
      setIn(0, 0, 0, 0, 0);
      #1 reset = 1'b1;
      mclear();
      #1;
      cmp("rst_empty", 0, 32'(emptyO[0]), 32'h1);
      cmp("rst_count", 0, 32'(cnt0), 32'h0);
      cmp("rst_stall", 0, 32'(stallO[0]), 32'h0);
      cmp("rst_rdata", 0, rdData[0], 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      // Store-to-load forwarding, then the same word from RAM.
      op(0, 1, 0, 32'h10, 32'hDEADBEEF);
      setIn(0, 0, 1, 32'h10, 0);
      #2;
      cmp("fwd_rdata", 0, rdData[0], 32'hDEADBEEF);
      cmp("fwd_stall", 0, 32'(stallO[0]), 32'h0);
      tick();
      drain(0);
      setIn(0, 0, 1, 32'h10, 0);
      #2;
      cmp("ram_rdata", 0, rdData[0], 32'hDEADBEEF);
      tick();
      // Youngest match wins.
      op(0, 1, 0, 32'h20, 32'h1);
      op(0, 1, 0, 32'h20, 32'h2);
      setIn(0, 0, 1, 32'h20, 0);
      #2;
      cmp("young_rdata", 0, rdData[0], 32'h2);
      tick();
      drain(0);
      // Full-buffer stall on the 2-entry, 4-cycle instance.
      setIn(1, 1, 0, 32'h30, 32'hAAAA0001);
      #2 cmp("full_c0", 1, 32'(stallO[1]), 32'h0);
      tick();
      setIn(1, 1, 0, 32'h34, 32'hBBBB0002);
      #2 cmp("full_c1", 1, 32'(stallO[1]), 32'h0);
      tick();
      setIn(1, 1, 0, 32'h38, 32'hCCCC0003);
      for (int c = 2; c < 5; c++) begin
         #2 cmp("full_stall", 1, 32'(stallO[1]), 32'h1);
         tick();
      end
      #2;
      cmp("full_c5", 1, 32'(stallO[1]), 32'h0);
      cmp("full_c5cnt", 1, 32'(cnt1), 32'h2);
      tick();
      setIn(1, 0, 0, 0, 0);
      #2 cmp("full_c6cnt", 1, 32'(cnt1), 32'h2);
      tick();
      drain(1);
      setIn(1, 0, 1, 32'h30, 0);
      #2 cmp("full_ramA", 1, rdData[1], 32'hAAAA0001);
      tick();
      // Load miss while a write is in flight.
      setIn(0, 1, 0, 32'h80, 32'h77);
      tick();
      setIn(0, 0, 0, 0, 0);
      tick();
      setIn(0, 0, 1, 32'h40, 0);
      #2 cmp("miss_s0", 0, 32'(stallO[0]), 32'h1);
      tick();
      #2 cmp("miss_s1", 0, 32'(stallO[0]), 32'h1);
      tick();
      #2;
      cmp("miss_s2", 0, 32'(stallO[0]), 32'h0);
      cmp("miss_rdata", 0, rdData[0], 32'h55);
      tick();
      drain(0);
      // Reset while the head is being written leaves RAM untouched.
      setIn(0, 1, 0, 32'h84, 32'hFEEDF00D);
      tick();
      setIn(0, 0, 0, 0, 0);
      tick();
      #1 reset = 1'b1;
      mclear();
      #1;
      cmp("rstw_empty", 0, 32'(emptyO[0]), 32'h1);
      cmp("rstw_count", 0, 32'(cnt0), 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      setIn(0, 0, 1, 32'h84, 0);
      #2 cmp("rstw_rdata", 0, rdData[0], pre[0][33]);
      tick();
      // Randomized traffic on each instance over a small address set.
      for (int k = 0; k < 2; k++) begin
         for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 9);
            a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFFFF00);
            op(k, r <= 3 || r == 7, (r >= 4 && r <= 7), a, $urandom);
         end
         drain(k);
      end
      chkOn = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
